dmux_rr_sched: RTL
==================

// Module: dmux_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one input stream among four consumers.
//  It holds one item in a single-entry output register and drives the 2-bit select (os1,os0) of the 1:4 demux.
//  Only channels that are enabled and present for selection are scheduled.
//  It counts completed transfers per channel for status readout.
//  It sits between the upstream producer and the demux/consumer stage.
// PARAMETERS
//  W   8  data width of idata/odata
//  CW  8  width of each per-channel transfer counter
// PORTS
//  iclk    in   1     clock, all logic on rising edge
//  irst    in   1     synchronous reset, active-high
//  idata   in   W     upstream data
//  ivalid  in   1     upstream item valid
//  oready  out  1     scheduler accepts item this cycle
//  ien     in   4     per-channel enable mask, bit k = channel k
//  odata   out  W     held item, shared by all channels
//  ovalid  out  4     one-hot valid to target channel
//  iready  in   4     per-channel consumer ready
//  os1     out  1     demux select MSB (target channel index bit 1)
//  os0     out  1     demux select LSB (target channel index bit 0)
//  ocnt    out  4*CW  transfer counters; ocnt[k*CW +: CW] = channel k
// BEHAVIOUR
//  Reset: the block has one clock; reset is synchronous and active-high. Reset values:
//   - state = S_EMPTY, odata = 0, ovalid = 0, {os1,os0} = 2'b00
//   - last-served pointer ptr = 3, so the first pick is channel 0
//   - all ocnt = 0
//  Reset mid-operation: a held item is discarded (not delivered), and counters clear.
//  States:
//   - S_EMPTY: nothing held.
//   - S_FULL: item held in odata, target in tgt.
//  Pick: nxt = first channel k with ien[k]=1, searched in order ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
//   - any_en = |ien.
//  Delivery: del = S_FULL & iready[tgt].
//  oready = any_en & (S_EMPTY | del). This is combinational; it gives back-to-back throughput of 1 item/cycle.
//  Capture when ivalid & oready:
//   - odata <= idata, tgt <= nxt, ptr <= nxt, state <= S_FULL.
//   - Latency: ovalid is asserted the cycle after capture.
//  On del without capture: state <= S_EMPTY; ovalid goes to 0 the next cycle; odata keeps its last value.
//  ovalid = S_FULL ? onehot(tgt) : 4'b0000.
//  {os1,os0} = tgt. The value is held while S_EMPTY, so the demux select never glitches.
//  Held item (S_FULL, no del):
//   - odata, ovalid and tgt are stable.
//   - There is no retargeting, even if iready changes on other channels.
//  ien changes while S_FULL: the held item is still delivered to tgt. The new ien is used only for the next pick.
//  ien = 0: oready = 0. A held item still drains to its target.
//  Counters: ocnt[k] increments on ovalid[k] & iready[k], modulo 2^CW (2^CW-1 wraps to 0).
//  Simultaneous deliver and capture in one cycle: the count for the old tgt increments, and the new item and tgt load together.
//  Pointer fairness: ptr advances only on capture, so a stalled target does not skip its turn.
// STRUCTURE
//  Shared include dmux_defs.vh:
//   - localparam NCH = 4
//   - state encodings S_EMPTY = 1'b0, S_FULL = 1'b1
//   - 2-bit channel index width
//  Sub-module rr_pick4: combinational rotate-priority picker.
//   - Inputs: ien[3:0], ptr[1:0].
//   - Outputs: nxt[1:0], any_en.
//  Top level: state/odata/tgt/ptr registers and four CW-bit counters.
// TESTING
//  1) irst pulse, then ien=1111, iready=1111, stream 0xA0..0xA7 back-to-back
//     -> targets 0,1,2,3,0,1,2,3; oready stays 1; each ocnt = 2.
//  2) ien=0101, all ready, 4 items
//     -> targets 0,2,0,2; ovalid never 0010 or 1000; ocnt0 = ocnt2 = 2.
//  3) Item 0x55 targeted at ch1 with iready[1]=0 for 5 cycles
//     -> ovalid = 0010, odata = 0x55, {os1,os0} = 01 stable, oready = 0.
//     -> After iready[1]=1: one transfer, ocnt1 +1.
//  4) ien=0000 -> oready = 0 indefinitely.
//     -> Clear ien while S_FULL at ch3: item is still delivered to ch3, then oready = 0.
//  5) CW=2, ien=0001, 5 items to ch0 -> ocnt0 = 1 (wrap); other counters 0.
//  6) irst asserted while S_FULL at ch2
//     -> next cycle ovalid = 0, ocnt all 0, {os1,os0} = 00.
//     -> The next item goes to ch0 with ien=1111.

Source files
------------

// File: rtl/dmux_rr_sched_pkg.sv
// Shared constants and types for the 4-way round-robin demux scheduler.
// Imported by the picker and the top level.
package dmux_rr_sched_pkg;
  localparam int NCH = 4;
  localparam int CIW = 2;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  function automatic logic [NCH-1:0] onehot(input logic [CIW-1:0] idx);
    onehot = NCH'(1) << idx;
  endfunction
endpackage

// File: rtl/dmux_rr_sched_rr_pick4.sv
// Rotate-priority picker: first enabled channel after ptr, wrapping so that
// ptr itself is searched last.
module rr_pick4
  import dmux_rr_sched_pkg::*;
(
  input  logic [NCH-1:0] ien_i,
  input  logic [CIW-1:0] ptr_i,
  output logic [CIW-1:0] nxt_o,
  output logic           any_en_o
);
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [CIW:0]     sh;
  logic [CIW-1:0]   off;

  always_comb begin
    sh  = {1'b0, ptr_i} + (CIW+1)'(1);
    dbl = {ien_i, ien_i};
    rot = NCH'(dbl >> sh);
    off = '0;
    // Descending scan leaves the lowest set offset, i.e. the nearest channel.
    for (int k = NCH-1; k >= 0; k--)
      if (rot[k]) off = CIW'(k);
    nxt_o    = CIW'(sh) + off;
    any_en_o = |ien_i;
  end
endmodule

// File: rtl/dmux_rr_sched.sv
// Round-robin scheduler feeding a 1:4 demux from one upstream stream through a
// single-entry holding register, with per-channel transfer counters.
module dmux_rr_sched
  import dmux_rr_sched_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic [W-1:0]      idata,
  input  logic              ivalid,
  output logic              oready,
  input  logic [NCH-1:0]    ien,
  output logic [W-1:0]      odata,
  output logic [NCH-1:0]    ovalid,
  input  logic [NCH-1:0]    iready,
  output logic              os1,
  output logic              os0,
  output logic [NCH*CW-1:0] ocnt
);
  state_e                     state_q, state_d;
  logic [W-1:0]               data_q, data_d;
  logic [CIW-1:0]             tgt_q, tgt_d;
  logic [CIW-1:0]             ptr_q, ptr_d;
  logic [NCH-1:0][CW-1:0]     cnt_q, cnt_d;

  logic [CIW-1:0] nxt;
  logic           any_en;
  logic           del, cap;

  rr_pick4 u_pick (
    .ien_i    (ien),
    .ptr_i    (ptr_q),
    .nxt_o    (nxt),
    .any_en_o (any_en)
  );

  assign del    = (state_q == S_FULL) && iready[tgt_q];
  assign oready = any_en && ((state_q == S_EMPTY) || del);
  assign cap    = ivalid && oready;

  assign odata      = data_q;
  assign ovalid     = (state_q == S_FULL) ? onehot(tgt_q) : '0;
  assign {os1, os0} = tgt_q;
  assign ocnt       = cnt_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tgt_d   = tgt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < NCH; k++)
      if (ovalid[k] && iready[k]) cnt_d[k] = cnt_q[k] + CW'(1);
    // Pointer moves only on capture so a stalled target keeps its turn.
    if (cap) begin
      state_d = S_FULL;
      data_d  = idata;
      tgt_d   = nxt;
      ptr_d   = nxt;
    end else if (del) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      tgt_q   <= '0;
      ptr_q   <= CIW'(NCH-1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tgt_q   <= tgt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
